// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the ROM address, absorbs the 1-cycle ROM
// latency and hands {pc, instr} to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_pc,
  input  logic              i_redirect,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_fault,
  output logic [31:0]       o_fetch_cnt
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_CAPT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pc_bad;

  // Misaligned or above the ROM's addressable range.
  assign pc_bad = (pc_q[1:0] != 2'b00) || ((pc_q >> ADDR_W) != 32'd0);

  // Next-state and datapath updates; redirect overrides everything but the count.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_REQ: begin
        if (pc_bad) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        instr_d = i_rom_data;
        opc_d   = pc_q;
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (valid_q && i_ready) begin
          cnt_d   = cnt_q + 32'd1;
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
    if (i_redirect) begin
      pc_d    = i_redirect_pc;
      valid_d = 1'b0;
      fault_d = 1'b0;
      instr_d = instr_q;
      opc_d   = opc_q;
      state_d = ST_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      opc_q   <= RESET_PC;
      fault_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_rom_addr  = pc_q[ADDR_W-1:0];
  assign o_valid     = valid_q;
  assign o_instr     = instr_q;
  assign o_pc        = opc_q;
  assign o_fault     = fault_q;
  assign o_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, checked
// against a transaction-level model of the fetch rules.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic        valid;
  logic        ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        fault;
  logic [31:0] fetch_cnt;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [0:4095];

  // Model state: current fetch pc, edges left until the word shows up.
  logic [31:0] m_pc, m_instr, m_opc, m_cnt;
  logic        m_valid, m_fault;
  int          m_wait;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_valid(valid), .i_ready(ready), .o_instr(instr), .o_pc(pc_out),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_fault(fault),
    .o_fetch_cnt(fetch_cnt)
  );

  // Registered-read ROM.
  always @(posedge clk) rom_data <= mem[rom_addr[13:2]];

  function automatic bit is_bad(logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'h0000_4000);
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_instr = 32'd0; m_opc = 32'd0; m_cnt = 32'd0;
    m_valid = 1'b0; m_fault = 1'b0; m_wait = 2;
  endtask

  task automatic model_step();
    bit hs;
    hs = m_valid && ready;
    if (hs) m_cnt = m_cnt + 32'd1;
    if (redirect) begin
      m_pc = redirect_pc; m_valid = 1'b0; m_fault = 1'b0; m_wait = 2;
    end else if (hs) begin
      m_pc = m_pc + 32'd4; m_valid = 1'b0; m_wait = 2;
    end else if (!m_valid && !m_fault) begin
      if (m_wait == 2 && is_bad(m_pc)) begin
        m_fault = 1'b1;
      end else begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_valid = 1'b1; m_instr = mem[m_pc[13:2]]; m_opc = m_pc;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_model();
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("fault", {31'd0, fault}, {31'd0, m_fault});
    chk("cnt", fetch_cnt, m_cnt);
    chk("rom_addr", {18'd0, rom_addr}, {18'd0, m_pc[13:0]});
    chk("instr", instr, m_instr);
    chk("pc", pc_out, m_opc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0093;
    mem[1] = 32'h0000_0113;
    model_reset();
    #12;
    do_reset();

    // Two-word stream with ready held high.
    ready = 1'b1;
    tick(); tick();
    chk("first_instr", instr, 32'h0000_0093);
    chk("first_pc", pc_out, 32'h0);
    tick(); tick(); tick();
    chk("second_instr", instr, 32'h0000_0113);
    chk("second_pc", pc_out, 32'h4);
    tick();
    chk("cnt_two", fetch_cnt, 32'd2);

    // Stall in HOLD.
    do_reset();
    ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) tick();
    chk("stall_valid", {31'd0, valid}, 32'd1);
    chk("stall_addr", {18'd0, rom_addr}, 32'd0);
    chk("stall_cnt", fetch_cnt, 32'd0);
    ready = 1'b1;
    tick();
    chk("stall_release_addr", {18'd0, rom_addr}, 32'd4);
    chk("stall_release_cnt", fetch_cnt, 32'd1);

    // Redirect during CAPT drops the in-flight word.
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_04e0;
    tick();
    redirect = 1'b0;
    chk("capt_redir_valid", {31'd0, valid}, 32'd0);
    chk("capt_redir_addr", {18'd0, rom_addr}, 32'h4e0);
    tick(); tick();
    chk("capt_redir_pc", pc_out, 32'h4e0);

    // Misaligned target faults; aligned redirect recovers.
    ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    tick();
    chk("misaligned_fault", {31'd0, fault}, 32'd1);
    ready = 1'b1;
    tick(); tick();
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0004;
    tick();
    redirect = 1'b0;
    chk("fault_cleared", {31'd0, fault}, 32'd0);
    tick(); tick();
    chk("resume_pc", pc_out, 32'h4);

    // Out-of-range target faults.
    redirect = 1'b1; redirect_pc = 32'h0001_0000;
    tick();
    redirect = 1'b0;
    tick();
    chk("range_fault", {31'd0, fault}, 32'd1);

    // Redirect coinciding with a HOLD handshake.
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0; ready = 1'b0;
    tick(); tick();
    begin
      logic [31:0] c0;
      c0 = m_cnt;
      ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
      tick();
      redirect = 1'b0;
      chk("hs_redir_cnt", fetch_cnt, c0 + 32'd1);
      chk("hs_redir_addr", {18'd0, rom_addr}, 32'h200);
    end

    // Async reset mid-HOLD.
    ready = 1'b0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_valid", {31'd0, valid}, 32'd0);
    chk("async_cnt", fetch_cnt, 32'd0);
    chk_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      ready = 1'($urandom % 2);
      redirect = ($urandom % 12) == 0;
      case ($urandom % 4)
        0: redirect_pc = $urandom & 32'h0000_3ffc;
        1: redirect_pc = ($urandom & 32'h0000_3ffc) | 32'd2;
        2: redirect_pc = ($urandom & 32'h0000_3ffc) | 32'h0008_0000;
        default: redirect_pc = 32'h0000_3ffc;
      endcase
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the multicycle RISC-V core, directly upstream of the instruction ROM.
- Owns the PC and drives the ROM byte address.
- Absorbs the ROM's 1-cycle registered read latency and latches the returned word into an instruction register.
- Presents {pc, instr} to the decode/control FSM over a valid/ready handshake; accepts redirects (branch/jump/trap targets) and flags misaligned or out-of-range PCs.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 14, ROM byte-address width; PC bits above ADDR_W-1 must be zero.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- o_rom_addr  output  ADDR_W  byte address to ROM; equals pc[ADDR_W-1:0].
- i_rom_data  input  32  ROM read data, valid the cycle after the address is presented.
- o_valid  output  1  instruction/pc outputs hold a fetched word.
- i_ready  input  1  consumer accepts the word this cycle.
- o_instr  output  32  latched instruction.
- o_pc  output  32  PC of o_instr.
- i_redirect  input  1  load new PC; discards any in-flight or held fetch.
- i_redirect_pc  input  32  redirect target.
- o_fault  output  1  PC misaligned (pc[1:0]!=0) or out of range (pc[31:ADDR_W]!=0).
- o_fetch_cnt  output  32  count of accepted instructions (handshakes).

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=REQ, o_valid=0, o_instr=0, o_pc=RESET_PC, o_fault=0, o_fetch_cnt=0. o_rom_addr tracks pc, so it reads RESET_PC[ADDR_W-1:0].
- States: REQ, CAPT, HOLD, FAULT.
- REQ:
  - pc is driving o_rom_addr.
  - If pc is bad (misaligned or out of range) -> FAULT, o_fault=1.
  - Otherwise -> CAPT.
- CAPT:
  - i_rom_data is valid for pc.
  - Edge: o_instr<=i_rom_data, o_pc<=pc, o_valid<=1 -> HOLD.
- HOLD:
  - o_valid=1; o_instr and o_pc are stable until accepted.
  - If o_valid&&i_ready at edge: o_fetch_cnt+=1 (wraps at 2^32), pc<=pc+4 (32-bit wrap), o_valid<=0 -> REQ.
- FAULT:
  - o_fault=1 and o_valid=0; stays here until a redirect.
  - i_ready is ignored.
- Redirect: i_redirect in any state at an edge has highest priority.
  - pc<=i_redirect_pc, o_valid<=0, o_fault<=0 -> REQ.
  - If it coincides with a HOLD handshake, the handshake still counts (o_fetch_cnt+=1), but pc comes from the redirect, not pc+4.
  - A redirect during CAPT drops the ROM word; o_instr is not updated.
- Latency: redirect/reset release to o_valid=1 is 2 edges (REQ, CAPT). Back-to-back throughput is 1 instruction per 3 cycles with i_ready held high.
- o_rom_addr is stable through CAPT and HOLD, so the ROM output is not disturbed.
- Reset asserted mid-operation clears all state immediately; there is no partial handshake.
- o_fault is combinationally independent of i_ready.

Test Plan:
- Reset release, ROM model word0=32'h00000093, word1=32'h00000113, i_ready=1 -> o_valid rises 2 cycles after release with o_instr=32'h00000093, o_pc=0. 3 cycles later o_instr=32'h00000113, o_pc=4, o_fetch_cnt=2 after the second accept.
- i_ready=0 for 5 cycles in HOLD -> o_valid stays 1 and o_instr/o_pc are unchanged, o_rom_addr=0, o_fetch_cnt=0. Raise i_ready -> pc=4, count=1.
- i_redirect with target 32'h0000_04e0 during CAPT -> the in-flight word is discarded, o_valid stays 0, and o_rom_addr=14'h04e0 next cycle. The next valid word has o_pc=32'h4e0.
- Redirect to 32'h0000_0102 -> o_fault=1 one cycle later, o_valid=0. Redirect to 32'h0000_0004 -> o_fault=0, normal fetch resumes.
- Redirect to 32'h0001_0000 (ADDR_W=14) -> o_fault=1. Redirect and handshake in the same edge in HOLD -> count+1, pc=redirect target.
- Assert rst_n=0 asynchronously in HOLD -> o_valid, o_fault and o_fetch_cnt are 0 and pc=RESET_PC without waiting for a clock edge.
